keypad_scan: RTL

- Input-side counterpart of the board's multiplexed 7-segment display driver: scans a 4x4 matrix keypad (Pmod KYPD layout) by driving one column low at a time and reading the four row returns.
- Debounces the result into one event per press.
- Delivers a 4-bit hex key code to the CPU's memory-mapped I/O through a valid/ack handshake.
- Sits beside the clock generator and display mux in the board top level, on the same system clock.

---
 rtl/keypad_pkg.sv | 32 +++
 rtl/keypad_debounce.sv | 99 +++++++++
 rtl/keypad_scan.sv | 115 +++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, sizes and key map for the 4x4 keypad scanner
package keypad_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;

  typedef enum logic [1:0] {
    IDLE,
    CANDIDATE,
    PRESSED,
    RELEASING
  } db_state_t;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } frame_res_t;

  // Pmod KYPD legend: digits 1..9 fill rows 0..2 of columns 0..2, column 3 is A..D.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (col == 2'd3)
      code = 4'hA + {2'b00, row};
    else if (row == 2'd3)
      code = 4'h0 - {2'b00, col};
    else
      code = 4'(row) * 4'd3 + 4'(col) + 4'd1;
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// rtl/keypad_debounce.sv - frame-level debounce, one press event per accepted key
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_stb,
  input  frame_res_t frame_res,
  input  logic [3:0] frame_key,
  output logic       press,
  output logic [3:0] key,
  output logic       key_held
);

  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CNT - 1);
  localparam logic [CW-1:0] DONE = CW'(DEBOUNCE_CNT);

  db_state_t     state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          match;

  assign match   = (frame_res == SINGLE) && (frame_key == key);
  assign cnt_inc = (cnt == DONE) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      key      <= '0;
      press    <= 1'b0;
      key_held <= 1'b0;
    end else begin
      press <= 1'b0;
      if (frame_stb) begin
        case (state)
          IDLE: begin
            if (frame_res == SINGLE) begin
              key <= frame_key;
              cnt <= CW'(1);
              if (DEBOUNCE_CNT == 1) begin
                state    <= PRESSED;
                press    <= 1'b1;
                key_held <= 1'b1;
              end else begin
                state <= CANDIDATE;
              end
            end
          end
          CANDIDATE: begin
            if (match) begin
              cnt <= cnt_inc;
              if (cnt == LAST) begin
                state    <= PRESSED;
                press    <= 1'b1;
                key_held <= 1'b1;
              end
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          PRESSED: begin
            if (!match) begin
              if (DEBOUNCE_CNT == 1) begin
                state    <= IDLE;
                cnt      <= '0;
                key_held <= 1'b0;
              end else begin
                state <= RELEASING;
                cnt   <= CW'(1);
              end
            end
          end
          RELEASING: begin
            if (match) begin
              state <= PRESSED;
              cnt   <= '0;
            end else if (cnt == LAST) begin
              state    <= IDLE;
              cnt      <= '0;
              key_held <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 keypad column scanner with debounced valid/ack key output
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 25000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       overrun
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  logic [NUM_ROWS-1:0]          row_meta;
  logic [NUM_ROWS-1:0]          row_sync;
  logic [DW-1:0]                dwell;
  logic [1:0]                   col_idx;
  logic [NUM_ROWS*NUM_COLS-1:0] acc;
  logic [NUM_ROWS*NUM_COLS-1:0] frame_bits;
  logic                         sample;
  logic                         frame_stb;
  frame_res_t                   frame_res;
  logic [3:0]                   frame_key;
  logic                         press;
  logic [3:0]                   press_key;

  assign sample    = (dwell == DWELL_LAST);
  assign frame_stb = sample && (col_idx == 2'(NUM_COLS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
    end
  end

  // Bit {row,col} of the frame map is set when that intersection reads low.
  always_comb begin
    frame_bits = acc;
    for (int r = 0; r < NUM_ROWS; r++)
      frame_bits[{2'(r), col_idx}] = ~row_sync[r];
  end

  always_comb begin
    frame_key = '0;
    for (int i = 0; i < NUM_ROWS * NUM_COLS; i++)
      if (frame_bits[i]) frame_key = 4'(i);
    case ($countones(frame_bits))
      0:       frame_res = NONE;
      1:       frame_res = SINGLE;
      default: frame_res = MULTI;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell   <= '0;
      col_idx <= '0;
      col_n   <= 4'b1110;
      acc     <= '0;
    end else if (sample) begin
      dwell   <= '0;
      col_idx <= col_idx + 2'd1;
      col_n   <= {col_n[2:0], col_n[3]};
      acc     <= frame_stb ? '0 : frame_bits;
    end else begin
      dwell <= dwell + 1'b1;
    end
  end

  keypad_debounce #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .frame_stb(frame_stb),
    .frame_res(frame_res),
    .frame_key(frame_key),
    .press    (press),
    .key      (press_key),
    .key_held (key_held)
  );

  // A press arriving while the previous code is still unread is dropped, not queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (press) begin
      if (key_valid && !key_ack) begin
        overrun <= 1'b1;
      end else begin
        key_code  <= key_map(press_key[3:2], press_key[1:0]);
        key_valid <= 1'b1;
        if (key_valid) overrun <= 1'b0;
      end
    end else if (key_valid && key_ack) begin
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end
  end

endmodule
